conversion_controller: RTL and testbench

CONVERSION_CONTROLLER -- requirements
Module: conversion_controller

---
 rtl/conversion_controller.sv | 167 ++++++++++++++++
 tb/tb_conversion_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conversion_controller.sv
// Periodic SAR ADC sequencer: a timed soc/eoc handshake captures samples into a
// one-deep buffer that is delivered to a consumer over a dav_/rfd handshake.
module conversion_controller #(
    parameter int unsigned PERIOD  = 100,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic       enable,
    output logic       soc,
    input  logic       eoc,
    input  logic [7:0] x7_x0,
    output logic [7:0] data,
    output logic       dav_,
    input  logic       rfd,
    input  logic       clear,
    output logic       overrun,
    output logic       timeout
);

    typedef enum logic [1:0] {A_IDLE, A_START, A_CONV, A_CAPTURE} a_state_t;
    typedef enum logic [1:0] {D_EMPTY, D_SETUP, D_VALID} d_state_t;

    localparam logic [15:0] PER_RELOAD = 16'(PERIOD - 1);
    localparam logic [7:0]  TO_LAST    = 8'(TIMEOUT - 1);

    logic [15:0] per_cnt_q, per_cnt_d;
    logic        tick;

    a_state_t    a_state_q, a_state_d;
    logic        soc_q, soc_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        capture, abort;

    logic [7:0]  buf_q, buf_d;
    logic        buf_full_q, buf_full_d;

    d_state_t    d_state_q, d_state_d;
    logic [7:0]  data_q, data_d;
    logic        dav_n_q, dav_n_d;
    logic        buf_read;

    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        per_cnt_d = per_cnt_q;
        tick      = 1'b0;
        if (enable) begin
            if (per_cnt_q == '0) begin
                tick      = 1'b1;
                per_cnt_d = PER_RELOAD;
            end else begin
                per_cnt_d = per_cnt_q - 16'd1;
            end
        end
    end

    // Ticks arriving outside A_IDLE, or while the converter is busy, are dropped.
    always_comb begin
        a_state_d = a_state_q;
        soc_d     = soc_q;
        to_cnt_d  = to_cnt_q;
        capture   = 1'b0;
        abort     = 1'b0;
        case (a_state_q)
            A_IDLE: begin
                if (tick && eoc) begin
                    soc_d     = 1'b1;
                    to_cnt_d  = '0;
                    a_state_d = A_START;
                end
            end
            A_START, A_CONV: begin
                if (to_cnt_q == TO_LAST) begin
                    abort     = 1'b1;
                    soc_d     = 1'b0;
                    a_state_d = A_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                    if (a_state_q == A_START && !eoc) begin
                        a_state_d = A_CONV;
                    end else if (a_state_q == A_CONV && eoc) begin
                        a_state_d = A_CAPTURE;
                    end
                end
            end
            A_CAPTURE: begin
                capture   = 1'b1;
                soc_d     = 1'b0;
                a_state_d = A_IDLE;
            end
            default: a_state_d = A_IDLE;
        endcase
    end

    always_comb begin
        d_state_d = d_state_q;
        data_d    = data_q;
        dav_n_d   = dav_n_q;
        buf_read  = 1'b0;
        case (d_state_q)
            D_EMPTY: begin
                if (buf_full_q && rfd) begin
                    buf_read  = 1'b1;
                    data_d    = buf_q;
                    d_state_d = D_SETUP;
                end
            end
            D_SETUP: begin
                dav_n_d   = 1'b0;
                d_state_d = D_VALID;
            end
            D_VALID: begin
                if (!rfd) begin
                    dav_n_d   = 1'b1;
                    d_state_d = D_EMPTY;
                end
            end
            default: d_state_d = D_EMPTY;
        endcase
    end

    // A capture coinciding with a read refills the buffer without flagging overrun.
    always_comb begin
        buf_d      = capture ? x7_x0 : buf_q;
        buf_full_d = capture | (buf_full_q & ~buf_read);
        overrun_d  = (capture && buf_full_q && !buf_read) ? 1'b1 :
                     (clear ? 1'b0 : overrun_q);
        timeout_d  = abort ? 1'b1 : (clear ? 1'b0 : timeout_q);
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            per_cnt_q  <= PER_RELOAD;
            a_state_q  <= A_IDLE;
            soc_q      <= 1'b0;
            to_cnt_q   <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            d_state_q  <= D_EMPTY;
            data_q     <= '0;
            dav_n_q    <= 1'b1;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            per_cnt_q  <= per_cnt_d;
            a_state_q  <= a_state_d;
            soc_q      <= soc_d;
            to_cnt_q   <= to_cnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            d_state_q  <= d_state_d;
            data_q     <= data_d;
            dav_n_q    <= dav_n_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign soc     = soc_q;
    assign data    = data_q;
    assign dav_    = dav_n_q;
    assign overrun = overrun_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_conversion_controller.sv
// Directed bench for conversion_controller with PERIOD=16, TIMEOUT=8; the bench
// plays both the SAR converter and the downstream consumer.
module tb_conversion_controller;

    logic       clock;
    logic       reset_;
    logic       enable;
    logic       soc;
    logic       eoc;
    logic [7:0] x7_x0;
    logic [7:0] data;
    logic       dav_;
    logic       rfd;
    logic       clear;
    logic       overrun;
    logic       timeout;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    conversion_controller #(
        .PERIOD (16),
        .TIMEOUT(8)
    ) dut (
        .clock  (clock),
        .reset_ (reset_),
        .enable (enable),
        .soc    (soc),
        .eoc    (eoc),
        .x7_x0  (x7_x0),
        .data   (data),
        .dav_   (dav_),
        .rfd    (rfd),
        .clear  (clear),
        .overrun(overrun),
        .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  val;
        bit          drop;      // converter drops eoc (0 = never responds)
        int unsigned len;       // cycles eoc is held low
        bit          exp_to;
        int unsigned exp_soc;   // cycles soc stays high
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_soc(input string nm);
        int unsigned n = 0;
        while (!soc && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk(nm, 32'(soc), 32'd1);
    endtask

    // Converter model: returns at the negedge where eoc goes back high with val.
    task automatic conv(input logic [7:0] val, input int unsigned len);
        wait_soc("soc_rise");
        eoc   = 1'b0;
        x7_x0 = ~val;
        repeat (len) @(negedge clock);
        eoc   = 1'b1;
        x7_x0 = val;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        int unsigned nsoc;

        vecs[0] = '{8'hA5, 1'b1, 3, 1'b0, 5};
        vecs[1] = '{8'h5A, 1'b1, 1, 1'b0, 3};
        vecs[2] = '{8'hFF, 1'b1, 6, 1'b0, 8};
        vecs[3] = '{8'h00, 1'b0, 0, 1'b1, 8};
        vecs[4] = '{8'h3C, 1'b1, 2, 1'b0, 4};
        vecs[5] = '{8'hC3, 1'b1, 5, 1'b0, 7};

        reset_ = 1'b0;
        enable = 1'b1;
        eoc    = 1'b1;
        x7_x0  = 8'h00;
        rfd    = 1'b1;
        clear  = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_soc",     32'(soc),     32'd0);
        chk("rst_dav_",    32'(dav_),    32'd1);
        chk("rst_data",    32'(data),    32'h00);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        reset_ = 1'b1;

        n = 0;
        while (!soc && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("first_soc_delay", n, 32'd16);

        for (int unsigned i = 0; i < 6; i++) begin
            wait_soc("tbl_soc_rise");
            if (vecs[i].drop) begin
                eoc   = 1'b0;
                x7_x0 = ~vecs[i].val;
            end
            n = 0;
            while (soc && n < 40) begin
                @(negedge clock);
                n++;
                if (vecs[i].drop && n == vecs[i].len) begin
                    eoc   = 1'b1;
                    x7_x0 = vecs[i].val;
                end
            end
            chk($sformatf("tbl%0d_soc_len", i), n, vecs[i].exp_soc);
            chk($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'(vecs[i].exp_to));
            chk($sformatf("tbl%0d_dav_idle", i), 32'(dav_), 32'd1);
            @(negedge clock);
            if (vecs[i].exp_to) begin
                chk($sformatf("tbl%0d_no_delivery", i), 32'(dav_), 32'd1);
                clear = 1'b1;
                @(negedge clock);
                clear = 1'b0;
                chk($sformatf("tbl%0d_timeout_clr", i), 32'(timeout), 32'd0);
            end else begin
                chk($sformatf("tbl%0d_data", i), 32'(data), 32'(vecs[i].val));
                chk($sformatf("tbl%0d_setup_dav_", i), 32'(dav_), 32'd1);
                @(negedge clock);
                chk($sformatf("tbl%0d_dav_low", i), 32'(dav_), 32'd0);
                rfd = 1'b0;
                @(negedge clock);
                chk($sformatf("tbl%0d_dav_release", i), 32'(dav_), 32'd1);
                chk($sformatf("tbl%0d_data_hold", i), 32'(data), 32'(vecs[i].val));
                chk($sformatf("tbl%0d_overrun", i), 32'(overrun), 32'd0);
                rfd = 1'b1;
            end
        end

        // Consumer stalled over two conversions: second sample overwrites first.
        rfd = 1'b0;
        conv(8'h11, 2);
        repeat (2) @(negedge clock);
        chk("ovr_first_none", 32'(overrun), 32'd0);
        chk("ovr_first_dav_", 32'(dav_), 32'd1);
        conv(8'h22, 2);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("ovr_set_beats_clear", 32'(overrun), 32'd1);
        @(negedge clock);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'd0);
        rfd = 1'b1;
        @(negedge clock);
        chk("ovr_data_newest", 32'(data), 32'h22);
        @(negedge clock);
        chk("ovr_dav_low", 32'(dav_), 32'd0);
        rfd = 1'b0;
        @(negedge clock);
        chk("ovr_dav_release", 32'(dav_), 32'd1);

        // Capture lands on the same edge that empties the buffer.
        conv(8'h33, 1);
        repeat (2) @(negedge clock);
        conv(8'h44, 1);
        @(negedge clock);
        rfd = 1'b1;
        @(negedge clock);
        chk("same_cyc_data", 32'(data), 32'h33);
        chk("same_cyc_overrun", 32'(overrun), 32'd0);
        @(negedge clock);
        chk("same_cyc_dav_low", 32'(dav_), 32'd0);
        chk("same_cyc_data_hold", 32'(data), 32'h33);
        rfd = 1'b0;
        @(negedge clock);
        chk("same_cyc_dav_rel", 32'(dav_), 32'd1);
        rfd = 1'b1;
        @(negedge clock);
        chk("same_cyc_second", 32'(data), 32'h44);
        @(negedge clock);
        chk("same_cyc_dav_low2", 32'(dav_), 32'd0);
        rfd = 1'b0;
        @(negedge clock);
        chk("same_cyc_dav_rel2", 32'(dav_), 32'd1);
        chk("same_cyc_overrun2", 32'(overrun), 32'd0);

        // Freeze the period counter with 11 cycles remaining.
        conv(8'h55, 1);
        repeat (3) @(negedge clock);
        enable = 1'b0;
        nsoc = 0;
        repeat (50) begin
            @(negedge clock);
            if (soc) nsoc++;
        end
        chk("en_off_no_soc", nsoc, 32'd0);
        enable = 1'b1;
        n = 0;
        while (!soc && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("en_resume_delay", n, 32'd12);

        // Reset in the middle of a conversion, converter still busy afterwards.
        eoc = 1'b0;
        @(negedge clock);
        chk("mid_conv_soc", 32'(soc), 32'd1);
        #2 reset_ = 1'b0;
        #1;
        chk("async_rst_soc",     32'(soc),     32'd0);
        chk("async_rst_dav_",    32'(dav_),    32'd1);
        chk("async_rst_data",    32'(data),    32'h00);
        chk("async_rst_overrun", 32'(overrun), 32'd0);
        chk("async_rst_timeout", 32'(timeout), 32'd0);
        @(negedge clock);
        reset_ = 1'b1;
        nsoc = 0;
        repeat (30) begin
            @(negedge clock);
            if (soc) nsoc++;
        end
        chk("rst_busy_no_soc", nsoc, 32'd0);
        eoc = 1'b1;
        n = 0;
        while (!soc && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("rst_next_tick", n, 32'd2);
        rfd   = 1'b1;
        eoc   = 1'b0;
        x7_x0 = 8'h66;
        @(negedge clock);
        eoc   = 1'b1;
        x7_x0 = 8'h99;
        repeat (3) @(negedge clock);
        chk("rst_after_data", 32'(data), 32'h99);
        @(negedge clock);
        chk("rst_after_dav_", 32'(dav_), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
